// File: rtl/iblk_rd_responder.sv
// Block-read responder: accepts a block read from the cache side, waits a
// fixed access latency, fetches four 32-bit words from a synchronous memory
// and returns them as one block with a single-cycle valid pulse.
module iblk_rd_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int BLK_WIDTH   = 128
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rstn,
  input  logic [3:0]           cpu_ren,
  input  logic [31:0]          cpu_raddr,
  output logic                 dev_rrdy,
  output logic                 dev_rvalid,
  output logic [BLK_WIDTH-1:0] dev_rdata,
  output logic                 mem_en,
  output logic [31:0]          mem_addr,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [3:0] LP_WAIT    = 4'(WAIT_CYCLES);
  localparam bit         LP_NO_WAIT = (WAIT_CYCLES == 0);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [2:0]            r_beat;
  logic [31:0]           r_base;
  logic [127:0]          r_asm;
  logic [BLK_WIDTH-1:0]  r_blk;
  logic                  w_req;

  // Any set bit of cpu_ren is a whole-block request; the pattern is irrelevant.
  assign w_req     = |cpu_ren;
  assign dev_rdata = r_blk;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state and Moore outputs; memory strobe only in the first four READ beats.
  always_comb begin
    w_state_nxt = r_state;
    dev_rrdy    = 1'b0;
    dev_rvalid  = 1'b0;
    mem_en      = 1'b0;
    mem_addr    = 32'h0;
    case (r_state)
      S_IDLE: begin
        dev_rrdy = 1'b1;
        if (w_req) w_state_nxt = LP_NO_WAIT ? S_READ : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) w_state_nxt = S_READ;
      end
      S_READ: begin
        if (r_beat < 3'd4) begin
          mem_en   = 1'b1;
          // Base is block aligned, so this add never carries out of the block.
          mem_addr = r_base + {27'h0, r_beat[1:0], 2'b00};
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        dev_rvalid  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, latency counter, beat counter and word assembly.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_cnt  <= 4'h0;
      r_beat <= 3'h0;
      r_base <= 32'h0;
      r_asm  <= 128'h0;
      r_blk  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_base <= {cpu_raddr[31:4], 4'b0000};
            r_cnt  <= LP_WAIT;
            r_beat <= 3'h0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_READ: begin
          r_beat <= r_beat + 3'd1;
          // Memory data lags the strobe by one cycle: beat k+1 carries word k.
          case (r_beat)
            3'd1: r_asm[31:0]   <= mem_rdata;
            3'd2: r_asm[63:32]  <= mem_rdata;
            3'd3: r_asm[95:64]  <= mem_rdata;
            3'd4: begin
              r_asm[127:96] <= mem_rdata;
              // Output block updates only here, so it holds between responses.
              r_blk <= BLK_WIDTH'({mem_rdata, r_asm[95:0]});
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iblk_rd_responder.sv
// Directed bench for iblk_rd_responder: one instance with the default
// latency and one with WAIT_CYCLES = 0, sharing request inputs and reset,
// each backed by its own 1-cycle-latency memory model.
module tb_iblk_rd_responder;

  logic         clk;
  logic         rstn;
  logic [3:0]   cpu_ren;
  logic [31:0]  cpu_raddr;
  bit           mem_mode;

  logic         a_rrdy, a_rvalid, a_en;
  logic [127:0] a_rdata;
  logic [31:0]  a_addr, a_mrd;
  logic         b_rrdy, b_rvalid, b_en;
  logic [127:0] b_rdata;
  logic [31:0]  b_addr, b_mrd;

  int n_chk;
  int n_err;

  iblk_rd_responder dut_a (
    .cpu_clk   (clk),
    .cpu_rstn  (rstn),
    .cpu_ren   (cpu_ren),
    .cpu_raddr (cpu_raddr),
    .dev_rrdy  (a_rrdy),
    .dev_rvalid(a_rvalid),
    .dev_rdata (a_rdata),
    .mem_en    (a_en),
    .mem_addr  (a_addr),
    .mem_rdata (a_mrd)
  );

  iblk_rd_responder #(.WAIT_CYCLES(0), .BLK_WIDTH(128)) dut_b (
    .cpu_clk   (clk),
    .cpu_rstn  (rstn),
    .cpu_ren   (cpu_ren),
    .cpu_raddr (cpu_raddr),
    .dev_rrdy  (b_rrdy),
    .dev_rvalid(b_rvalid),
    .dev_rdata (b_rdata),
    .mem_en    (b_en),
    .mem_addr  (b_addr),
    .mem_rdata (b_mrd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: mode 0 tags each word with its address, mode 1 is a fixed pattern.
  function automatic logic [31:0] mem_f(input logic [31:0] a, input bit m);
    if (m) begin
      case (a[3:2])
        2'd0:    return 32'h11111111;
        2'd1:    return 32'h22222222;
        2'd2:    return 32'h33333333;
        default: return 32'h44444444;
      endcase
    end
    return {a[15:0], 16'hBEEF};
  endfunction

  // One-cycle read latency; junk when not strobed so mistimed captures show.
  always @(posedge clk) begin
    a_mrd <= a_en ? mem_f(a_addr, mem_mode) : 32'hDEAD0000;
    b_mrd <= b_en ? mem_f(b_addr, mem_mode) : 32'hDEAD0000;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-cycle control/strobe expectations for a DUT with latency w, cycle c after E0.
  task automatic check_cycle(input string nm, input int c, input int w, input logic [31:0] base,
                             input logic rrdy, input logic rvalid, input logic en,
                             input logic [31:0] addr);
    logic        e_en;
    logic [31:0] e_addr;
    e_en   = (c >= w + 1) && (c <= w + 4);
    e_addr = e_en ? base + 32'(4 * (c - w - 1)) : 32'h0;
    chk($sformatf("%s c%0d rrdy", nm, c),   {127'h0, rrdy},   {127'h0, !(c >= 1 && c <= w + 6)});
    chk($sformatf("%s c%0d rvalid", nm, c), {127'h0, rvalid}, {127'h0, (c == w + 6)});
    chk($sformatf("%s c%0d mem_en", nm, c), {127'h0, en},     {127'h0, e_en});
    chk($sformatf("%s c%0d mem_addr", nm, c), {96'h0, addr},  {96'h0, e_addr});
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (!(a_rrdy && b_rrdy) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " idle"}, {127'h0, (a_rrdy && b_rrdy)}, {127'h0, 1'b1});
  endtask

  // Single request seen by both instances; address is scrambled while busy.
  task automatic run_single(input string nm, input logic [3:0] ren, input logic [31:0] addr,
                            input bit mode, input logic [31:0] base, input logic [127:0] blk);
    mem_mode  = mode;
    @(posedge clk); #1;
    cpu_ren   = ren;
    cpu_raddr = addr;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) cpu_ren = 4'h0;
      if (c == 2) cpu_raddr = 32'hDEADBEE0;
      check_cycle({nm, " A"}, c, 2, base, a_rrdy, a_rvalid, a_en, a_addr);
      check_cycle({nm, " B"}, c, 0, base, b_rrdy, b_rvalid, b_en, b_addr);
      if (c == 8)  chk({nm, " A rdata"}, a_rdata, blk);
      if (c == 6)  chk({nm, " B rdata"}, b_rdata, blk);
      if (c == 10) begin
        chk({nm, " A rdata hold"}, a_rdata, blk);
        chk({nm, " B rdata hold"}, b_rdata, blk);
      end
    end
  endtask

  localparam logic [127:0] BLK_1C  = 128'h001CBEEF_0018BEEF_0014BEEF_0010BEEF;
  localparam logic [127:0] BLK_PAT = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] BLK_TOP = 128'hFFFCBEEF_FFF8BEEF_FFF4BEEF_FFF0BEEF;
  localparam logic [127:0] BLK_100 = 128'h010CBEEF_0108BEEF_0104BEEF_0100BEEF;
  localparam logic [127:0] BLK_200 = 128'h020CBEEF_0208BEEF_0204BEEF_0200BEEF;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rstn      = 1'b0;
    cpu_ren   = 4'hF;
    cpu_raddr = 32'h12345678;
    mem_mode  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst A rrdy",   {127'h0, a_rrdy},   {127'h0, 1'b1});
    chk("rst A rvalid", {127'h0, a_rvalid}, 128'h0);
    chk("rst A mem_en", {127'h0, a_en},     128'h0);
    chk("rst A addr",   {96'h0, a_addr},    128'h0);
    chk("rst A rdata",  a_rdata,            128'h0);
    chk("rst B rrdy",   {127'h0, b_rrdy},   {127'h0, 1'b1});
    chk("rst B rdata",  b_rdata,            128'h0);
    cpu_ren = 4'h0;
    #2 rstn = 1'b1;

    run_single("blk1C",  4'hF,    32'h1C000014, 1'b0, 32'h1C000010, BLK_1C);
    run_single("pat40",  4'b0001, 32'h00000040, 1'b1, 32'h00000040, BLK_PAT);
    run_single("wrap",   4'hF,    32'hFFFFFFF4, 1'b0, 32'hFFFFFFF0, BLK_TOP);

    // Back-to-back: request held continuously, address changed while busy.
    mem_mode = 1'b0;
    wait_idle("b2b pre");
    cpu_ren   = 4'hF;
    cpu_raddr = 32'h00000100;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      if (c == 2) cpu_raddr = 32'h00000200;
      if (c == 3) chk("b2b c3 addr",  {96'h0, a_addr}, {96'h0, 32'h00000100});
      if (c == 8) begin
        chk("b2b c8 rvalid", {127'h0, a_rvalid}, {127'h0, 1'b1});
        chk("b2b c8 rdata",  a_rdata, BLK_100);
      end
      if (c == 9) begin
        chk("b2b c9 rrdy",   {127'h0, a_rrdy},   {127'h0, 1'b1});
        chk("b2b c9 rvalid", {127'h0, a_rvalid}, 128'h0);
      end
      if (c == 10) chk("b2b c10 rrdy", {127'h0, a_rrdy}, 128'h0);
      if (c == 12) begin
        chk("b2b c12 mem_en", {127'h0, a_en},    {127'h0, 1'b1});
        chk("b2b c12 addr",   {96'h0, a_addr},   {96'h0, 32'h00000200});
        chk("b2b c12 rdata",  a_rdata, BLK_100);
      end
      if (c == 16) chk("b2b c16 rvalid", {127'h0, a_rvalid}, 128'h0);
      if (c == 17) begin
        chk("b2b c17 rvalid", {127'h0, a_rvalid}, {127'h0, 1'b1});
        chk("b2b c17 rdata",  a_rdata, BLK_200);
      end
      if (c == 18) cpu_ren = 4'h0;
    end
    wait_idle("b2b post");

    // Reset pulse in cycle 4 of a default-latency transaction.
    @(posedge clk); #1;
    cpu_ren   = 4'hF;
    cpu_raddr = 32'h1C000014;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) cpu_ren = 4'h0;
    end
    chk("mid c4 mem_en pre", {127'h0, a_en}, {127'h0, 1'b1});
    rstn = 1'b0;
    #1;
    chk("mid rst A mem_en", {127'h0, a_en},     128'h0);
    chk("mid rst A addr",   {96'h0, a_addr},    128'h0);
    chk("mid rst A rvalid", {127'h0, a_rvalid}, 128'h0);
    chk("mid rst A rrdy",   {127'h0, a_rrdy},   {127'h0, 1'b1});
    chk("mid rst A rdata",  a_rdata,            128'h0);
    chk("mid rst B mem_en", {127'h0, b_en},     128'h0);
    #2 rstn = 1'b1;
    for (int c = 5; c <= 14; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post rst c%0d A rvalid", c), {127'h0, a_rvalid}, 128'h0);
      chk($sformatf("post rst c%0d A mem_en", c), {127'h0, a_en},     128'h0);
      chk($sformatf("post rst c%0d A rrdy", c),   {127'h0, a_rrdy},   {127'h0, 1'b1});
      chk($sformatf("post rst c%0d B rvalid", c), {127'h0, b_rvalid}, 128'h0);
      chk($sformatf("post rst c%0d B mem_en", c), {127'h0, b_en},     128'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
